// File: rtl/fpnew_opgroup_reorder_buffer.sv
// Issue-order retirement buffer for an FPU operation group: slices write back out of order,
// results leave in issue order. Optional same-cycle head bypass under FPNEW_ROB_BYPASS_EN.
module fpnew_opgroup_reorder_buffer #(
    parameter int unsigned NumSlices = 4,
    parameter int unsigned Width     = 64,
    parameter int unsigned Depth     = 8,
    parameter int unsigned TagWidth  = 8,
    localparam int unsigned IdxW     = $clog2(Depth)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [TagWidth-1:0]       issue_tag_i,
    output logic [IdxW-1:0]           issue_id_o,
    input  logic [NumSlices-1:0]      slc_valid_i,
    output logic [NumSlices-1:0]      slc_ready_o,
    input  logic [NumSlices*IdxW-1:0] slc_id_i,
    input  logic [NumSlices*Width-1:0] slc_result_i,
    input  logic [NumSlices*5-1:0]    slc_status_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [Width-1:0]          result_o,
    output logic [4:0]                status_o,
    output logic [TagWidth-1:0]       tag_o,
    output logic                      busy_o,
    output logic                      error_o
);

    logic [IdxW:0]         head_q, tail_q;
    logic [IdxW-1:0]       head_idx, tail_idx;
    logic                  empty, full;
    logic [Depth-1:0]      alloc_q, done_q;
    logic [Width-1:0]      result_q [Depth];
    logic [4:0]            status_q [Depth];
    logic [TagWidth-1:0]   tag_q    [Depth];
    logic                  error_q;
    logic [IdxW-1:0]       slc_id [NumSlices];
    logic [NumSlices-1:0]  wb_ok, wb_bad;
    logic                  issue_fire, retire;

    assign head_idx = head_q[IdxW-1:0];
    assign tail_idx = tail_q[IdxW-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[IdxW] != tail_q[IdxW]);

    assign issue_ready_o = !full && !flush_i;
    assign issue_fire    = issue_valid_i && issue_ready_o;
    assign issue_id_o    = tail_idx;
    assign slc_ready_o   = {NumSlices{!flush_i}};
    assign busy_o        = !empty;
    assign error_o       = error_q;

    always_comb begin
        for (int unsigned s = 0; s < NumSlices; s++) begin
            slc_id[s] = slc_id_i[s*IdxW +: IdxW];
        end
    end

    // A write lands only on an allocated, pending slot that no other slice targets this cycle.
    always_comb begin
        logic collide;
        collide = 1'b0;
        wb_ok   = '0;
        wb_bad  = '0;
        for (int unsigned s = 0; s < NumSlices; s++) begin
            if (slc_valid_i[s] && !flush_i) begin
                collide = 1'b0;
                for (int unsigned t = 0; t < NumSlices; t++) begin
                    if (t != s && slc_valid_i[t] && slc_id[t] == slc_id[s]) begin
                        collide = 1'b1;
                    end
                end
                if (!collide && alloc_q[slc_id[s]] && !done_q[slc_id[s]]) begin
                    wb_ok[s] = 1'b1;
                end else begin
                    wb_bad[s] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid_o = !empty && done_q[head_idx];
        result_o    = result_q[head_idx];
        status_o    = status_q[head_idx];
`ifdef FPNEW_ROB_BYPASS_EN
        for (int unsigned s = 0; s < NumSlices; s++) begin
            if (wb_ok[s] && slc_id[s] == head_idx) begin
                out_valid_o = 1'b1;
                result_o    = slc_result_i[s*Width +: Width];
                status_o    = slc_status_i[s*5 +: 5];
            end
        end
`endif
    end

    assign tag_o  = tag_q[head_idx];
    assign retire = out_valid_o && out_ready_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            error_q <= 1'b0;
            for (int unsigned i = 0; i < Depth; i++) begin
                result_q[i] <= '0;
                status_q[i] <= '0;
                tag_q[i]    <= '0;
            end
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            done_q  <= '0;
        end else begin
            for (int unsigned s = 0; s < NumSlices; s++) begin
                if (wb_ok[s]) begin
                    result_q[slc_id[s]] <= slc_result_i[s*Width +: Width];
                    status_q[slc_id[s]] <= slc_status_i[s*5 +: 5];
                    done_q[slc_id[s]]   <= 1'b1;
                end
            end
            if (|wb_bad) begin
                error_q <= 1'b1;
            end
            // Retire comes after writeback so a bypassed head never keeps its done bit.
            if (retire) begin
                alloc_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
                head_q            <= head_q + 1'b1;
            end
            if (issue_fire) begin
                alloc_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                tag_q[tail_idx]   <= issue_tag_i;
                tail_q            <= tail_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpnew_opgroup_reorder_buffer.sv
// Scoreboard bench for the reorder buffer: expected results are queued in issue order and a
// negedge monitor compares every retirement; directed scenarios plus a randomized phase.
module tb_fpnew_opgroup_reorder_buffer;

    localparam int NS = 4;
    localparam int W  = 64;
    localparam int D  = 8;
    localparam int TW = 8;
    localparam int IW = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush;
    logic             issue_valid;
    logic             issue_ready;
    logic [TW-1:0]    issue_tag;
    logic [IW-1:0]    issue_id;
    logic [NS-1:0]    slc_valid;
    logic [NS-1:0]    slc_ready;
    logic [NS*IW-1:0] slc_id;
    logic [NS*W-1:0]  slc_result;
    logic [NS*5-1:0]  slc_status;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [4:0]       status;
    logic [TW-1:0]    tag;
    logic             busy;
    logic             error;

    fpnew_opgroup_reorder_buffer #(
        .NumSlices(NS), .Width(W), .Depth(D), .TagWidth(TW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .issue_valid_i(issue_valid),
        .issue_ready_o(issue_ready),
        .issue_tag_i  (issue_tag),
        .issue_id_o   (issue_id),
        .slc_valid_i  (slc_valid),
        .slc_ready_o  (slc_ready),
        .slc_id_i     (slc_id),
        .slc_result_i (slc_result),
        .slc_status_i (slc_status),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .result_o     (result),
        .status_o     (status),
        .tag_o        (tag),
        .busy_o       (busy),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic [4:0]    st;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        expq[$];
    int          pend[$];
    int          issued_total = 0;
    int          retired_total = 0;
    logic [W-1:0] res_of [D];
    logic [4:0]  st_of [D];
    logic        hold_prev = 1'b0;
    logic [W+5+TW-1:0] prev_vec;
    exp_t        mon_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted output must match the oldest outstanding issue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !flush) begin
                if (hold_prev) begin
                    check("hold_stable", {out_valid, result, status, tag}, {1'b1, prev_vec});
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out: result 0x%0h tag 0x%0h with no op", result, tag);
                    end else begin
                        mon_e = expq.pop_front();
                        check("out_data", {result, status, tag}, {mon_e.res, mon_e.st, mon_e.tag});
                        retired_total++;
                    end
                end
                hold_prev = out_valid && !out_ready;
                prev_vec  = {result, status, tag};
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic clr();
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_tag   = '0;
        slc_valid   = '0;
        slc_id      = '0;
        slc_result  = '0;
        slc_status  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic model_clear();
        expq.delete();
        pend.delete();
        issued_total  = 0;
        retired_total = 0;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        clr();
        out_ready = 1'b0;
        mid();
        check("rst_issue_ready", issue_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_issue_id", issue_id, 0);
        check("rst_error", error, 0);
        check("rst_data", {result, status, tag}, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_issue(input logic [TW-1:0] t, input logic [W-1:0] r, input logic [4:0] s);
        int id;
        id        = issued_total % D;
        res_of[id] = r;
        st_of[id]  = s;
        expq.push_back('{tag: t, res: r, st: s});
        issued_total++;
        issue_valid = 1'b1;
        issue_tag   = t;
    endtask

    task automatic set_wb(input int s, input int id);
        logic [IW-1:0] idv;
        idv = IW'(id);
        slc_valid[s]           = 1'b1;
        slc_id[s*IW +: IW]     = idv;
        slc_result[s*W +: W]   = res_of[id];
        slc_status[s*5 +: 5]   = st_of[id];
    endtask

    initial begin
        clr();
        out_ready = 1'b0;
        reset_dut();

        // In-order retirement of reverse-order writebacks.
        out_ready = 1'b1;
        do_issue(8'd1, 64'hA, 5'h01); mid(); check("inord_id0", issue_id, 0); tick();
        do_issue(8'd2, 64'hB, 5'h02); mid(); check("inord_id1", issue_id, 1); tick();
        do_issue(8'd3, 64'hC, 5'h04); mid(); check("inord_id2", issue_id, 2); tick();
        mid(); check("inord_busy", busy, 1); check("inord_idle_valid", out_valid, 0); tick();
        set_wb(0, 2); mid(); check("inord_wb2_valid", out_valid, 0); tick();
        set_wb(1, 1); mid(); check("inord_wb1_valid", out_valid, 0); tick();
        set_wb(2, 0);
`ifndef FPNEW_ROB_BYPASS_EN
        mid(); check("inord_wb0_valid", out_valid, 0); tick();
        for (int i = 0; i < 3; i++) begin
            mid(); check("inord_b2b_valid", out_valid, 1); tick();
        end
        mid(); check("inord_after_valid", out_valid, 0); check("inord_after_busy", busy, 0);
        tick();
`else
        for (int i = 0; i < 4; i++) tick();
`endif
        check("inord_drain", expq.size(), 0);

        // Full buffer, no ready-through, wrap to slot 0.
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < D; i++) begin
            do_issue(TW'(8'h10 + i), {$urandom, $urandom}, 5'($urandom));
            mid(); check("full_fill_ready", issue_ready, 1); tick();
        end
        issue_valid = 1'b1; mid(); check("full_ready", issue_ready, 0); check("full_busy", busy, 1);
        tick();
        issue_valid = 1'b1; set_wb(0, 0); mid(); check("full_ready_wb", issue_ready, 0); tick();
        issue_valid = 1'b1; mid();
        check("full_head_valid", out_valid, 1); check("full_no_ready_through", issue_ready, 0);
        tick();
        do_issue(8'h99, 64'h5555_AAAA_0000_FFFF, 5'h1F); mid();
        check("full_reopen_ready", issue_ready, 1); check("full_wrap_id", issue_id, 0); tick();
        issue_valid = 1'b1; mid(); check("full_again_ready", issue_ready, 0); tick();
        for (int s = 0; s < NS; s++) set_wb(s, s + 1);
        tick();
        set_wb(0, 5); set_wb(1, 6); set_wb(2, 7); set_wb(3, 0);
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("full_drain", expq.size(), 0);
        check("full_err", error, 0);

        // Backpressure holds the head.
        reset_dut();
        do_issue(8'h77, 64'h1234_5678_9ABC_DEF0, 5'h03); tick();
        set_wb(2, 0); tick();
        for (int i = 0; i < 4; i++) begin
            mid(); check("bp_valid", out_valid, 1); check("bp_result", result, 64'h1234_5678_9ABC_DEF0);
            tick();
        end
        out_ready = 1'b1; mid(); check("bp_release_valid", out_valid, 1); tick();
        mid(); check("bp_retired", retired_total, 1); check("bp_empty", busy, 0); tick();

        // Illegal writebacks: unallocated target, then a same-slot collision.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            do_issue(TW'(8'h40 + i), {$urandom, $urandom}, 5'($urandom)); tick();
        end
        set_wb(0, 5); mid(); check("ill_err_before", error, 0); tick();
        mid(); check("ill_err_unalloc", error, 1); tick();
        slc_valid[1] = 1'b1; slc_id[1*IW +: IW] = 3'd3; slc_result[1*W +: W] = 64'hDEAD;
        slc_valid[2] = 1'b1; slc_id[2*IW +: IW] = 3'd3; slc_result[2*W +: W] = 64'hBEEF;
        tick();
        mid(); check("ill_err_sticky", error, 1); check("ill_no_valid", out_valid, 0); tick();
        out_ready = 1'b1;
        for (int s = 0; s < NS; s++) set_wb(s, s);
        tick();
        for (int i = 0; i < 6; i++) tick();
        check("ill_drain", expq.size(), 0);
        check("ill_err_end", error, 1);

        // Flush with work in flight.
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            do_issue(TW'(8'h50 + i), {$urandom, $urandom}, 5'($urandom)); tick();
        end
        set_wb(0, 0); set_wb(1, 1); tick();
        tick();
        flush = 1'b1; issue_valid = 1'b1; mid();
        check("fl_issue_ready", issue_ready, 0); check("fl_slc_ready", slc_ready, 0);
        tick();
        model_clear();
        mid();
        check("fl_busy", busy, 0); check("fl_valid", out_valid, 0);
        check("fl_id", issue_id, 0); check("fl_err", error, 0);
        tick();
        set_wb(0, 1); mid(); check("fl_late_err_before", error, 0); tick();
        mid(); check("fl_late_err", error, 1); tick();

`ifdef FPNEW_ROB_BYPASS_EN
        reset_dut();
        out_ready = 1'b1;
        do_issue(8'h66, 64'hCAFE_F00D, 5'h08); tick();
        set_wb(3, 0); mid();
        check("byp_valid", out_valid, 1); check("byp_result", result, 64'hCAFE_F00D);
        tick();
        mid(); check("byp_busy", busy, 0); tick();
`endif

        // Randomized traffic against the queue model.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            int cnt;
            int id_exp;
            cnt    = issued_total - retired_total;
            id_exp = issued_total % D;
            out_ready = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < NS; s++) begin
                if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                    int k;
                    k = $urandom_range(0, pend.size() - 1);
                    set_wb(s, pend[k]);
                    pend.delete(k);
                end
            end
            if (cnt < D && $urandom_range(0, 1) == 1) begin
                pend.push_back(issued_total % D);
                do_issue(TW'($urandom), {$urandom, $urandom}, 5'($urandom));
            end
            mid();
            check("rnd_issue_ready", issue_ready, cnt < D);
            check("rnd_busy", busy, cnt != 0);
            check("rnd_issue_id", issue_id, id_exp);
            check("rnd_err", error, 0);
            tick();
        end
        for (int c = 0; c < 300 && expq.size() != 0; c++) begin
            out_ready = 1'b1;
            for (int s = 0; s < NS; s++) begin
                if (pend.size() > 0) begin
                    set_wb(s, pend[0]);
                    void'(pend.pop_front());
                end
            end
            tick();
        end
        check("rnd_drain", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
